// File: rtl/mac_pkg.sv
// Shared types and constants for the product accumulator: FSM state encoding,
// product width, and signed-range helpers for an arbitrary accumulator width.
package mac_pkg;

    localparam int unsigned PROD_W    = 64;
    localparam int unsigned MAX_ACC_W = 128;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    // Largest positive two's-complement value in w bits, zero-extended.
    function automatic logic [MAX_ACC_W-1:0] ACC_MAX(input int unsigned w);
        return (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
    endfunction

    // Most negative value in w bits: only the sign bit set.
    function automatic logic [MAX_ACC_W-1:0] ACC_MIN(input int unsigned w);
        return MAX_ACC_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input and sum output handshakes of the product accumulator.
// master: the surrounding system; slave: the accumulator.
interface product_accumulator_if #(
    parameter int unsigned ACC_W = 72
);
    import mac_pkg::*;

    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              prod_ready;
    logic              sum_valid;
    logic [ACC_W-1:0]  sum;
    logic              sum_ready;
    logic              overflow;

    modport master (
        output prod_valid,
        output prod,
        output sum_ready,
        input  prod_ready,
        input  sum_valid,
        input  sum,
        input  overflow
    );

    modport slave (
        input  prod_valid,
        input  prod,
        input  sum_ready,
        output prod_ready,
        output sum_valid,
        output sum,
        output overflow
    );

endinterface

// File: rtl/prod_fifo.sv
// Small circular FIFO for incoming products. Pointers carry an extra wrap bit so
// full and empty come straight from a pointer compare.
module prod_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of DOT_LEN signed products into an ACC_W-bit dot product.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned DOT_LEN    = 4,
    parameter int unsigned ACC_W      = 72,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  clr,
    product_accumulator_if.slave bus
);

    localparam int unsigned CNT_W = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DOT_LEN - 1);

    state_e            r_state;
    state_e            w_state_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_d;
    logic [ACC_W-1:0]  r_sum;
    logic [ACC_W-1:0]  w_sum_d;
    logic              r_sum_valid;
    logic              w_sum_valid_d;
    logic              r_overflow;
    logic              w_overflow_d;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [PROD_W-1:0] w_rdata;
    logic [ACC_W-1:0]  w_x;
    logic [ACC_W-1:0]  w_sum_raw;
    logic              w_add_ovf;
    logic [ACC_W-1:0]  w_acc_upd;

    prod_fifo #(
        .WIDTH (PROD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (clr),
        .i_push  (bus.prod_valid),
        .i_wdata (bus.prod),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_rdata)
    );

    assign bus.prod_ready = !w_full;
    assign bus.sum_valid  = r_sum_valid;
    assign bus.sum        = r_sum;
    assign bus.overflow   = r_overflow;

    assign w_pop     = !w_empty && (r_state != StHold);
    assign w_x       = ACC_W'($signed(w_rdata));
    assign w_sum_raw = r_acc + w_x;
    // Only a real add can overflow; the first element of a group is a plain load.
    assign w_add_ovf = (r_cnt != '0) &&
                       (r_acc[ACC_W-1] == w_x[ACC_W-1]) &&
                       (w_sum_raw[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(ACC_MAX(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(ACC_MIN(ACC_W));

    always_comb begin
        w_acc_upd = w_sum_raw;
        if (r_cnt == '0) begin
            w_acc_upd = w_x;
        end else if (w_add_ovf) begin
            w_acc_upd = r_acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        w_acc_upd = w_sum_raw;
        if (r_cnt == '0) w_acc_upd = w_x;
    end
`endif

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_acc_d       = r_acc;
        w_sum_d       = r_sum;
        w_sum_valid_d = r_sum_valid;
        w_overflow_d  = r_overflow;
        unique case (r_state)
            StIdle, StAccum: begin
                if (w_pop) begin
                    w_acc_d      = w_acc_upd;
                    w_overflow_d = r_overflow | w_add_ovf;
                    if (r_cnt == LAST_CNT) begin
                        w_cnt_d       = '0;
                        w_sum_d       = w_acc_upd;
                        w_sum_valid_d = 1'b1;
                        w_state_d     = StHold;
                    end else begin
                        w_cnt_d   = r_cnt + 1'b1;
                        w_state_d = StAccum;
                    end
                end
            end
            StHold: begin
                if (bus.sum_ready) begin
                    w_sum_valid_d = 1'b0;
                    w_state_d     = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_acc       <= w_acc_d;
            r_sum       <= w_sum_d;
            r_sum_valid <= w_sum_valid_d;
            r_overflow  <= w_overflow_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 72-bit and a 64-bit instance share one stimulus
// stream; a per-width arithmetic model predicts every completed sum and overflow flag.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        prod_valid = 1'b0;
    logic [63:0] prod = '0;
    logic        sum_ready = 1'b1;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(72)) if72 ();
    product_accumulator_if #(.ACC_W(64)) if64 ();

    assign if72.prod_valid = prod_valid;
    assign if72.prod       = prod;
    assign if72.sum_ready  = sum_ready;
    assign if64.prod_valid = prod_valid;
    assign if64.prod       = prod;
    assign if64.sum_ready  = sum_ready;

    product_accumulator #(.DOT_LEN(4), .ACC_W(72), .FIFO_DEPTH(4)) u_dut72 (
        .clk (clk), .rst (rst), .clr (clr), .bus (if72.slave)
    );
    product_accumulator #(.DOT_LEN(4), .ACC_W(64), .FIFO_DEPTH(4)) u_dut64 (
        .clk (clk), .rst (rst), .clr (clr), .bus (if64.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: mathematical running sums per group, clamped or wrapped into range.
    typedef struct {
        logic signed [127:0] sum;
        bit                  ovf;
    } exp_t;

    exp_t                q0[$];
    exp_t                q1[$];
    logic signed [127:0] m_acc [2];
    int                  m_cnt [2];
    bit                  m_ovf [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = '0;
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_add(input int d, input logic signed [63:0] p);
        int unsigned         w   = (d == 0) ? 72 : 64;
        logic signed [127:0] x   = 128'(p);
        logic signed [127:0] one = 128'sd1;
        logic signed [127:0] mx  = (one <<< (w - 1)) - one;
        logic signed [127:0] mn  = -(one <<< (w - 1));
        logic signed [127:0] s;
        exp_t                e;
        if (m_cnt[d] == 0) begin
            s = x;
        end else begin
            s = m_acc[d] + x;
            if (s > mx || s < mn) begin
                m_ovf[d] = 1'b1;
`ifdef ACC_SATURATE_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - (one <<< w) : s + (one <<< w);
`endif
            end
        end
        m_acc[d] = s;
        m_cnt[d]++;
        if (m_cnt[d] == 4) begin
            m_cnt[d] = 0;
            e.sum = s;
            e.ovf = m_ovf[d];
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endfunction

    int                  cyc = 0;
    int                  last_push_cyc = 0;
    int                  sv_rise_cyc = 0;
    int                  n_valid72 = 0;
    bit                  prev_sv72 = 1'b0;
    logic signed [127:0] last_sum72 = '0;
    logic signed [127:0] last_sum64 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are observed mid-cycle, where inputs and outputs are both settled.
    always @(negedge clk) begin
        exp_t e;
        if (rst || clr) begin
            model_reset();
            prev_sv72 = 1'b0;
        end else begin
            if (if72.prod_valid && if72.prod_ready) begin
                model_add(0, if72.prod);
                last_push_cyc = cyc;
            end
            if (if64.prod_valid && if64.prod_ready) model_add(1, if64.prod);
            if (if72.sum_valid) n_valid72++;
            if (if72.sum_valid && !prev_sv72) sv_rise_cyc = cyc;
            prev_sv72 = if72.sum_valid;
            if (if72.sum_valid && if72.sum_ready) begin
                if (q0.size() == 0) begin
                    check_eq("unexpected_sum72", 128'($signed(if72.sum)), 128'hx);
                end else begin
                    e = q0.pop_front();
                    last_sum72 = 128'($signed(if72.sum));
                    check_eq("sum72", last_sum72, e.sum);
                    check_eq("ovf72", 128'(if72.overflow), 128'(e.ovf));
                end
            end
            if (if64.sum_valid && if64.sum_ready) begin
                if (q1.size() == 0) begin
                    check_eq("unexpected_sum64", 128'($signed(if64.sum)), 128'hx);
                end else begin
                    e = q1.pop_front();
                    last_sum64 = 128'($signed(if64.sum));
                    check_eq("sum64", last_sum64, e.sum);
                    check_eq("ovf64", 128'(if64.overflow), 128'(e.ovf));
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] p);
        bit done = 1'b0;
        prod_valid = 1'b1;
        prod       = p;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            done = if72.prod_ready;
            @(posedge clk);
            #1;
        end
        prod_valid = 1'b0;
        if (!done) check_eq("push_timeout", 128'd0, 128'd1);
    endtask

    logic signed [127:0] one128 = 128'sd1;
    logic signed [127:0] exp64;
    int                  v0;
    bit                  seen;
    logic [31:0]         r;

    initial begin
        model_reset();
        tick(3);
        @(negedge clk);
        check_eq("rst_prod_ready", 128'(if72.prod_ready), 128'd1);
        check_eq("rst_sum_valid", 128'(if72.sum_valid), 128'd0);
        check_eq("rst_sum", 128'(if72.sum), 128'd0);
        check_eq("rst_overflow", 128'(if64.overflow), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);

        // Basic group: 3 - 5 + 7 + 10.
        v0 = n_valid72;
        push(64'd3);
        push(-64'sd5);
        push(64'd7);
        push(64'd10);
        tick(4);
        check_eq("basic_sum72", last_sum72, 128'sd15);
        check_eq("basic_sum64", last_sum64, 128'sd15);
        check_eq("basic_valid_cycles", 128'(n_valid72 - v0), 128'd1);
        check_eq("basic_latency", 128'(sv_rise_cyc - last_push_cyc), 128'd2);
        check_eq("basic_ovf", 128'(if72.overflow), 128'd0);

        // Backpressure: sum held while the FIFO fills behind it.
        sum_ready = 1'b0;
        push(64'd1);
        push(64'd2);
        push(64'd3);
        push(64'd4);
        push(64'd100);
        push(-64'sd200);
        push(64'd300);
        push(-64'sd400);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("bp_prod_ready", 128'(if72.prod_ready), 128'd0);
            check_eq("bp_sum_valid", 128'(if72.sum_valid), 128'd1);
            check_eq("bp_sum_stable", 128'($signed(if72.sum)), 128'sd10);
        end
        @(posedge clk);
        #1 sum_ready = 1'b1;
        tick(12);
        check_eq("bp_second_sum", last_sum72, -128'sd200);
        check_eq("bp_ready_after", 128'(if72.prod_ready), 128'd1);

        // Four large negatives: fits in 72 bits, overflows 64 bits.
        for (int i = 0; i < 4; i++) push(64'hC000_0000_0000_0000);
        tick(6);
        check_eq("neg_sum72", last_sum72, -(one128 <<< 64));
        check_eq("neg_ovf72", 128'(if72.overflow), 128'd0);
`ifdef ACC_SATURATE_EN
        exp64 = -(one128 <<< 63);
`else
        exp64 = '0;
`endif
        check_eq("neg_sum64", last_sum64, exp64);
        check_eq("neg_ovf64", 128'(if64.overflow), 128'd1);

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check_eq("clr_ovf64", 128'(if64.overflow), 128'd0);
        check_eq("clr_ready", 128'(if64.prod_ready), 128'd1);

        // Positive overflow: 2^62 + 2^62 in 64 bits.
        push(64'h4000_0000_0000_0000);
        push(64'h4000_0000_0000_0000);
        push(64'd0);
        push(64'd0);
        tick(6);
        check_eq("pos_sum72", last_sum72, one128 <<< 63);
        check_eq("pos_ovf72", 128'(if72.overflow), 128'd0);
`ifdef ACC_SATURATE_EN
        exp64 = (one128 <<< 63) - one128;
`else
        exp64 = -(one128 <<< 63);
`endif
        check_eq("pos_sum64", last_sum64, exp64);
        check_eq("pos_ovf64", 128'(if64.overflow), 128'd1);

        // Asynchronous reset while a sum is held.
        sum_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = if64.sum_valid;
        end
        check_eq("hold_reached", 128'(seen), 128'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_sum_valid", 128'(if64.sum_valid), 128'd0);
        check_eq("arst_sum", 128'(if64.sum), 128'd0);
        check_eq("arst_overflow", 128'(if64.overflow), 128'd0);
        check_eq("arst_ready", 128'(if72.prod_ready), 128'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        sum_ready = 1'b1;
        tick(2);

        // Clear mid-group discards it.
        push(64'd5);
        push(64'd6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) push(64'd1);
        tick(6);
        check_eq("clr_sum72", last_sum72, 128'sd4);
        check_eq("clr_sum64", last_sum64, 128'sd4);
        check_eq("clr_ovf", 128'(if72.overflow), 128'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            prod_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: prod = {$urandom, $urandom};
                1: prod = {{32{r[31]}}, r};
                2: prod = {2'b01, 30'($urandom), r};
                default: prod = {2'b10, 30'($urandom), r};
            endcase
            sum_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        prod_valid = 1'b0;
        sum_ready  = 1'b1;
        for (int i = 0; i < 4 && m_cnt[0] != 0; i++) push(64'($urandom_range(0, 99)));
        tick(30);
        check_eq("drain_q72", 128'(q0.size()), 128'd0);
        check_eq("drain_q64", 128'(q1.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
